// File: rtl/opt_run_sequencer_if.sv
// opt_run_sequencer_if: host-side run-control bundle between the register block and opt_run_sequencer.
interface opt_run_sequencer_if #(
  parameter int PHASE_NUM = 5,
  parameter int PHASE_W   = 8,
  parameter int ITER_W    = 16,
  parameter int COM_W     = 2
);
  logic                         start;
  logic                         abort;
  logic [ITER_W-1:0]            iterations;
  logic [PHASE_NUM*PHASE_W-1:0] phase_len;
  logic [COM_W-1:0]             com_even;
  logic [COM_W-1:0]             com_odd;
  logic                         exchange_valid;
  logic                         opt_run;
  logic [COM_W-1:0]             opt_com;
  logic                         busy;
  logic                         done;
  logic                         aborted;
  logic [ITER_W-1:0]            iter_idx;
  logic [31:0]                  cycle_count;
  modport master (
    output start, abort, iterations, phase_len, com_even, com_odd,
    input  exchange_valid, opt_run, opt_com, busy, done, aborted, iter_idx, cycle_count
  );
  modport slave (
    input  start, abort, iterations, phase_len, com_even, com_odd,
    output exchange_valid, opt_run, opt_com, busy, done, aborted, iter_idx, cycle_count
  );
endinterface

// File: rtl/opt_run_sequencer.sv
// opt_run_sequencer: hardware iteration/phase sequencer driving top's exchange_valid/opt_run/opt_com.
// Define SEQ_CYCLE_CNT_EN to build the saturating busy-cycle counter behind cycle_count.
module opt_run_sequencer #(
  parameter int PHASE_NUM = 5,
  parameter int PHASE_W   = 8,
  parameter int ITER_W    = 16,
  parameter int COM_W     = 2
) (
  input logic clk,
  input logic reset,
  opt_run_sequencer_if.slave s
);
  localparam int PI_W = $clog2(PHASE_NUM + 2);
  localparam int LW   = PHASE_NUM * PHASE_W;
  typedef enum logic [2:0] {IDLE, SETUP, RUN, PHASE, GAP, FIN} state_t;
  state_t state_q, state_d;
  logic [ITER_W-1:0] iters_q, iters_d, iter_q, iter_d;
  logic [LW-1:0] len_q, len_d;
  logic [COM_W-1:0] ce_q, ce_d, co_q, co_d, com_q, com_d;
  logic [PI_W-1:0] ph_q, ph_d, nz;
  logic [PHASE_W-1:0] cnt_q, cnt_d;
  logic ev_q, ev_d, run_q, run_d, busy_q, busy_d, done_q, done_d, ab_q, ab_d;
  // First phase at or after 'from' with a non-zero length; PHASE_NUM when none remain.
  function automatic logic [PI_W-1:0] next_nz(input logic [LW-1:0] l, input logic [PI_W-1:0] from);
    next_nz = PI_W'(PHASE_NUM);
    for (int i = PHASE_NUM - 1; i >= 0; i--)
      if (PI_W'(i) >= from && l[i*PHASE_W +: PHASE_W] != '0) next_nz = PI_W'(i);
  endfunction
  // Out-of-range index yields 1 so an all-zero iteration still spends one PHASE cycle.
  function automatic logic [PHASE_W-1:0] plen(input logic [LW-1:0] l, input logic [PI_W-1:0] p);
    plen = PHASE_W'(1);
    for (int i = 0; i < PHASE_NUM; i++)
      if (PI_W'(i) == p) plen = l[i*PHASE_W +: PHASE_W];
  endfunction
  always_comb begin
    state_d = state_q;
    iters_d = iters_q;
    iter_d  = iter_q;
    len_d   = len_q;
    ce_d    = ce_q;
    co_d    = co_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    nz      = next_nz(len_q, state_q == RUN ? '0 : ph_q + PI_W'(1));
    case (state_q)
      IDLE: if (s.start) begin
        iters_d = s.iterations;
        len_d   = s.phase_len;
        ce_d    = s.com_even;
        co_d    = s.com_odd;
        iter_d  = '0;
        state_d = s.iterations == '0 ? FIN : SETUP;
      end
      SETUP: state_d = RUN;
      RUN: begin
        state_d = PHASE;
        ph_d    = nz;
        cnt_d   = plen(len_q, nz);
      end
      PHASE: if (cnt_q > PHASE_W'(1)) cnt_d = cnt_q - PHASE_W'(1);
        else if (nz != PI_W'(PHASE_NUM)) begin
          ph_d  = nz;
          cnt_d = plen(len_q, nz);
        end
        else if (iter_q == iters_q - ITER_W'(1)) state_d = FIN;
        else begin
          iter_d  = iter_q + ITER_W'(1);
          state_d = GAP;
        end
      GAP: state_d = SETUP;
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ab_d = state_q != IDLE && s.abort;
    if (ab_d) begin
      state_d = IDLE;
      iter_d  = iter_q;
    end
    ev_d   = state_d inside {SETUP, RUN, PHASE};
    run_d  = state_d == RUN;
    com_d  = run_d ? (iter_d[0] ? co_d : ce_d) : '0;
    busy_d = state_d inside {SETUP, RUN, PHASE, GAP};
    done_d = state_d == FIN;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      iters_q <= '0;
      iter_q  <= '0;
      len_q   <= '0;
      ce_q    <= '0;
      co_q    <= '0;
      com_q   <= '0;
      ph_q    <= '0;
      cnt_q   <= '0;
      ev_q    <= 1'b0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ab_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      iters_q <= iters_d;
      iter_q  <= iter_d;
      len_q   <= len_d;
      ce_q    <= ce_d;
      co_q    <= co_d;
      com_q   <= com_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      ev_q    <= ev_d;
      run_q   <= run_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ab_q    <= ab_d;
    end
  assign s.exchange_valid = ev_q;
  assign s.opt_run        = run_q;
  assign s.opt_com        = com_q;
  assign s.busy           = busy_q;
  assign s.done           = done_q;
  assign s.aborted        = ab_q;
  assign s.iter_idx       = iter_q;
`ifdef SEQ_CYCLE_CNT_EN
  logic [31:0] cc_q, cc_d;
  always_comb cc_d = state_q == IDLE && s.start ? '0 : busy_q && cc_q != '1 ? cc_q + 32'd1 : cc_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) cc_q <= '0;
    else cc_q <= cc_d;
  assign s.cycle_count = cc_q;
`else
  assign s.cycle_count = '0;
`endif
endmodule

// File: tb/tb_opt_run_sequencer.sv
// tb_opt_run_sequencer: table-driven, directed and randomized checks of opt_run_sequencer
// against a per-cycle trace derived from the iteration/phase timing rules.
module tb_opt_run_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  opt_run_sequencer_if bus ();
  opt_run_sequencer dut (.clk(clk), .reset(reset), .s(bus.slave));
  typedef struct {
    logic ev, run, busy, done, ab;
    logic [1:0] com;
    logic [15:0] it;
    logic [31:0] cc;
  } cyc_t;
  typedef struct {
    int n;
    logic [39:0] len;
    logic [1:0] ce, co;
    int done_at;
    int abort_at;
    int restart_at;
    bit ab_start;
  } vec_t;
  cyc_t q[$];
  vec_t vt[6];
  int passed = 0;
  int total = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  function automatic logic [39:0] pk(input int a, input int b, input int c, input int d, input int e);
    return {8'(e), 8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction
  // Expected trace: cycle k after start acceptance is q[k-1]; last entry is the FIN cycle.
  task automatic build(input int n, input logic [39:0] len, input logic [1:0] ce, input logic [1:0] co);
    int s = 0;
    int b = 0;
    cyc_t c;
    q.delete();
    for (int p = 0; p < 5; p++) s += int'(len[p*8 +: 8]);
    if (s == 0) s = 1;
    for (int i = 0; i < n; i++)
      for (int k = 0; k < s + 3; k++)
        if (!(k == s + 2 && i == n - 1)) begin
          c.ev = k < s + 2;
          c.run = k == 1;
          c.com = (i % 2 == 1) ? co : ce;
          c.busy = 1'b1;
          c.done = 1'b0;
          c.ab = 1'b0;
          c.it = 16'(k == s + 2 ? i + 1 : i);
          c.cc = 32'(b);
          b++;
          q.push_back(c);
        end
    c = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b0, 16'(n == 0 ? 0 : n - 1), 32'(b)};
    q.push_back(c);
  endtask
  task automatic cmp(input cyc_t e, input string tag, input int k);
    chk($sformatf("%s c%0d", tag, k),
        {9'b0, bus.exchange_valid, bus.opt_run, bus.busy, bus.done, bus.aborted, e.run ? bus.opt_com : 2'b0, bus.iter_idx},
        {9'b0, e.ev, e.run, e.busy, e.done, e.ab, e.run ? e.com : 2'b0, e.it});
`ifdef SEQ_CYCLE_CNT_EN
    chk($sformatf("%s cc c%0d", tag, k), bus.cycle_count, e.cc);
`else
    chk($sformatf("%s cc c%0d", tag, k), bus.cycle_count, 32'd0);
`endif
  endtask
  task automatic run(input vec_t v, input string tag);
    int seen = -1;
    int last;
    int ab_at;
    cyc_t pst;
    build(v.n, v.len, v.ce, v.co);
    ab_at = v.abort_at;
    if (ab_at < 0) ab_at = (q.size() > 1 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, q.size() - 1)) : 0;
    last = ab_at > 0 ? ab_at : q.size();
    bus.iterations = 16'(v.n);
    bus.phase_len = v.len;
    bus.com_even = v.ce;
    bus.com_odd = v.co;
    bus.start = 1'b1;
    bus.abort = v.ab_start;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.iterations = 16'($urandom);
    bus.phase_len = {8'($urandom), 32'($urandom)};
    bus.com_even = 2'($urandom);
    bus.com_odd = 2'($urandom);
    for (int k = 1; k <= last; k++) begin
      cmp(q[k-1], tag, k);
      if (bus.done) seen = k;
      if (k == v.restart_at) bus.start = 1'b1;
      if (k == ab_at) bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
    end
    pst = '{1'b0, 1'b0, 1'b0, 1'b0, ab_at > 0, 2'b0, q[last-1].it, q[last-1].cc + (ab_at > 0 ? 32'd1 : 32'd0)};
    cmp(pst, {tag, " post"}, last + 1);
    if (v.done_at > 0) chk({tag, " done_at"}, 32'(seen), 32'(v.done_at));
    if (ab_at > 0) chk({tag, " no_done"}, 32'(seen), 32'hffff_ffff);
  endtask
  initial begin
    vec_t r;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.iterations = '0;
    bus.phase_len = '0;
    bus.com_even = '0;
    bus.com_odd = '0;
    vt[0] = '{1, pk(20, 20, 20, 20, 20), 2'd2, 2'd0, 103, 0, 0, 1'b0};
    vt[1] = '{3, pk(4, 0, 0, 0, 1), 2'd1, 2'd3, 24, 0, 0, 1'b0};
    vt[2] = '{0, pk(5, 5, 5, 5, 5), 2'd1, 2'd1, 1, 0, 0, 1'b0};
    vt[3] = '{2, 40'd0, 2'd3, 2'd1, 8, 0, 0, 1'b0};
    vt[4] = '{1, pk(20, 20, 20, 20, 20), 2'd2, 2'd1, 0, 50, 0, 1'b0};
    vt[5] = '{2, pk(3, 1, 0, 2, 0), 2'd2, 2'd1, 18, 0, 5, 1'b1};
    repeat (2) @(posedge clk);
    #1;
    chk("reset outs", {9'b0, bus.exchange_valid, bus.opt_run, bus.busy, bus.done, bus.aborted, bus.opt_com, bus.iter_idx}, 32'd0);
    chk("reset cc", bus.cycle_count, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    chk("idle abort ignored", {30'b0, bus.aborted, bus.busy}, 32'd0);
    for (int i = 0; i < 6; i++) run(vt[i], $sformatf("vec%0d", i));
    bus.iterations = 16'd1;
    bus.phase_len = pk(20, 20, 20, 20, 20);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (30) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async reset outs", {9'b0, bus.exchange_valid, bus.opt_run, bus.busy, bus.done, bus.aborted, bus.opt_com, bus.iter_idx}, 32'd0);
    chk("async reset cc", bus.cycle_count, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    run(vt[5], "after reset");
    for (int i = 0; i < 12; i++) begin
      r.n = int'($urandom_range(0, 4));
      for (int p = 0; p < 5; p++) r.len[p*8 +: 8] = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
      r.ce = 2'($urandom);
      r.co = 2'($urandom);
      r.done_at = 0;
      r.abort_at = -1;
      r.restart_at = int'($urandom_range(0, 6));
      r.ab_start = 1'($urandom);
      run(r, $sformatf("rnd%0d", i));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
